// File: rtl/decl_check.sv
// Byte-serial checker for C-style declarations: ws* TYPE ws+ ID (ws* ',' ws* ID)* ws* ';'
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   in, in_valid   ASCII character and its qualifier
//   out            one-cycle pulse after the ';' of a legal statement
//   id_count       identifier count of the last accepted statement (saturating)
//   type_char      type of the last accepted statement (0 = int, 1 = char)
module decl_check #(
  parameter int unsigned MAX_ID_LEN  = 8,
  parameter int unsigned CNT_W       = 4,
  parameter bit          ENABLE_CHAR = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in,
  input  logic             in_valid,
  output logic             out,
  output logic [CNT_W-1:0] id_count,
  output logic             type_char
);

  localparam int unsigned      LEN_W   = $clog2(MAX_ID_LEN + 2);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_ID_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [3:0] {
    START, TYPE_I, TYPE_N, TYPE_T, TYPE_C, TYPE_H, TYPE_A, TYPE_R,
    TYPE_WS, LIST_WS, IDENT, POST_WS, ACCEPT, ERR
  } state_t;

  typedef enum logic [2:0] {
    KW_NONE, KW_I, KW_IN, KW_INT, KW_C, KW_CH, KW_CHA, KW_CHAR
  } kw_t;

  state_t           state;
  kw_t              kw;
  kw_t              kw_next;
  kw_t              kw_first;
  logic [LEN_W-1:0] len;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             cur_char;

  logic is_ws, is_alpha, is_digit, is_id_start, is_id_char, is_semi, is_comma, is_kw_id;

  // Character classes
  assign is_ws       = (in == 8'h20) || (in == 8'h09);
  assign is_alpha    = ((in >= 8'h41) && (in <= 8'h5A)) || ((in >= 8'h61) && (in <= 8'h7A));
  assign is_digit    = (in >= 8'h30) && (in <= 8'h39);
  assign is_id_start = is_alpha || (in == 8'h5F);
  assign is_id_char  = is_id_start || is_digit;
  assign is_semi     = (in == 8'h3B);
  assign is_comma    = (in == 8'h2C);

  assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
  assign is_kw_id = (kw == KW_INT) || (kw == KW_CHAR);
  assign kw_first = (in == 8'h69) ? KW_I : ((in == 8'h63) ? KW_C : KW_NONE);

  // Keyword-prefix tracker: follows "int"/"char" only while the ID still spells a prefix
  always_comb begin
    kw_next = KW_NONE;
    case (kw)
      KW_I:    if (in == 8'h6E) kw_next = KW_IN;
      KW_IN:   if (in == 8'h74) kw_next = KW_INT;
      KW_C:    if (in == 8'h68) kw_next = KW_CH;
      KW_CH:   if (in == 8'h61) kw_next = KW_CHA;
      KW_CHA:  if (in == 8'h72) kw_next = KW_CHAR;
      default: kw_next = KW_NONE;
    endcase
  end

  // Statement FSM with registered results
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= START;
      kw        <= KW_NONE;
      len       <= '0;
      cnt       <= '0;
      cur_char  <= 1'b0;
      out       <= 1'b0;
      id_count  <= '0;
      type_char <= 1'b0;
    end else begin
      out <= 1'b0;
      if (!in_valid) begin
        // ACCEPT never outlives one cycle, even without a new character
        if (state == ACCEPT) state <= START;
      end else begin
        case (state)
          START, ACCEPT: begin
            if (is_ws || is_semi) begin
              state <= START;
            end else if (in == 8'h69) begin
              state    <= TYPE_I;
              cnt      <= '0;
              cur_char <= 1'b0;
            end else if (ENABLE_CHAR && (in == 8'h63)) begin
              state    <= TYPE_C;
              cnt      <= '0;
              cur_char <= 1'b1;
            end else begin
              state <= ERR;
            end
          end
          TYPE_I: state <= (in == 8'h6E) ? TYPE_N : (is_semi ? START : ERR);
          TYPE_N: state <= (in == 8'h74) ? TYPE_T : (is_semi ? START : ERR);
          TYPE_C: state <= (in == 8'h68) ? TYPE_H : (is_semi ? START : ERR);
          TYPE_H: state <= (in == 8'h61) ? TYPE_A : (is_semi ? START : ERR);
          TYPE_A: state <= (in == 8'h72) ? TYPE_R : (is_semi ? START : ERR);
          TYPE_T, TYPE_R: state <= is_ws ? TYPE_WS : (is_semi ? START : ERR);
          TYPE_WS, LIST_WS: begin
            if (is_id_start) begin
              state <= IDENT;
              len   <= LEN_W'(1);
              kw    <= kw_first;
            end else if (!is_ws) begin
              state <= is_semi ? START : ERR;
            end
          end
          IDENT: begin
            if (is_id_char) begin
              if (len == LEN_MAX) begin
                state <= ERR;
              end else begin
                len <= len + LEN_W'(1);
                kw  <= kw_next;
              end
            end else if (is_ws || is_comma || is_semi) begin
              if (is_kw_id) begin
                // Reserved word as an ID: the statement dies; its own ';' already ends it
                state <= is_semi ? START : ERR;
              end else begin
                cnt <= cnt_inc;
                if (is_semi) begin
                  state     <= ACCEPT;
                  out       <= 1'b1;
                  id_count  <= cnt_inc;
                  type_char <= cur_char;
                end else begin
                  state <= is_comma ? LIST_WS : POST_WS;
                end
              end
            end else begin
              state <= ERR;
            end
          end
          POST_WS: begin
            if (is_comma) begin
              state <= LIST_WS;
            end else if (is_semi) begin
              state     <= ACCEPT;
              out       <= 1'b1;
              id_count  <= cnt;
              type_char <= cur_char;
            end else if (!is_ws) begin
              state <= ERR;
            end
          end
          ERR: if (is_semi) state <= START;
          default: state <= ERR;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_decl_check.sv
// Scoreboard bench for decl_check: one instance with char enabled, one without.
module tb_decl_check;

  localparam int unsigned MAXL = 8;
  localparam int unsigned CW   = 4;

  typedef logic [7:0] ch_t;
  typedef struct packed {
    logic [CW-1:0] cnt;
    logic          tc;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  ch_t           in_ch;
  logic          out_a, out_b, tc_a, tc_b;
  logic [CW-1:0] cnt_a, cnt_b;

  int            checks = 0;
  int            errors = 0;
  exp_t          exp_q [2][$];
  logic [CW-1:0] held_c [2];
  logic          held_t [2];
  int            pushed [2];
  int            popped [2];
  bit            mon_en = 1'b0;
  int unsigned   gap_lo = 0;
  int unsigned   gap_hi = 2;
  ch_t           sbuf[$];
  ch_t           gen[$];

  decl_check #(.MAX_ID_LEN(MAXL), .CNT_W(CW), .ENABLE_CHAR(1'b1)) dut_a (
    .clk(clk), .reset(reset), .in(in_ch), .in_valid(in_valid),
    .out(out_a), .id_count(cnt_a), .type_char(tc_a));

  decl_check #(.MAX_ID_LEN(MAXL), .CNT_W(CW), .ENABLE_CHAR(1'b0)) dut_b (
    .clk(clk), .reset(reset), .in(in_ch), .in_valid(in_valid),
    .out(out_b), .id_count(cnt_b), .type_char(tc_b));

  always #5 clk = ~clk;

  function automatic bit c_ws(input ch_t c);
    return (c == 8'd32) || (c == 8'd9);
  endfunction

  function automatic bit c_start(input ch_t c);
    return (c >= "a" && c <= "z") || (c >= "A" && c <= "Z") || (c == "_");
  endfunction

  function automatic bit c_idch(input ch_t c);
    return c_start(c) || (c >= "0" && c <= "9");
  endfunction

  function automatic bit kw_at(input ch_t s[$], input int i, input string k);
    for (int j = 0; j < k.len(); j++)
      if (i + j >= s.size() || s[i+j] != ch_t'(k[j])) return 1'b0;
    return 1'b1;
  endfunction

  // Reference parser over one statement body (everything before the ';')
  function automatic void model(input ch_t s[$], input bit en, output bit ok,
                                output logic [CW-1:0] cnt, output bit tc);
    int i, n, st, ids;
    ok = 1'b0; cnt = '0; tc = 1'b0; n = s.size(); i = 0; ids = 0;
    while (i < n && c_ws(s[i])) i++;
    if (kw_at(s, i, "int")) begin tc = 1'b0; i += 3; end
    else if (en && kw_at(s, i, "char")) begin tc = 1'b1; i += 4; end
    else return;
    if (i >= n || !c_ws(s[i])) return;
    while (1) begin
      while (i < n && c_ws(s[i])) i++;
      st = i;
      if (i >= n || !c_start(s[i])) return;
      while (i < n && c_idch(s[i])) i++;
      if (i - st > int'(MAXL)) return;
      if ((i - st == 3 && kw_at(s, st, "int")) || (i - st == 4 && kw_at(s, st, "char"))) return;
      if (ids < (1 << CW) - 1) ids++;
      while (i < n && c_ws(s[i])) i++;
      if (i >= n) break;
      if (s[i] != 8'h2C) return;
      i++;
    end
    ok  = 1'b1;
    cnt = CW'(ids);
  endfunction

  task automatic feed(input ch_t c);
    bit ok, tc;
    logic [CW-1:0] cn;
    exp_t e;
    if (c == 8'h3B) begin
      for (int k = 0; k < 2; k++) begin
        model(sbuf, k == 0, ok, cn, tc);
        if (ok) begin
          e.cnt = cn;
          e.tc  = tc;
          exp_q[k].push_back(e);
          pushed[k]++;
        end
      end
      sbuf.delete();
    end else begin
      sbuf.push_back(c);
    end
  endtask

  task automatic send(input ch_t c);
    int unsigned g;
    g = $urandom_range(gap_hi, gap_lo);
    repeat (g) begin
      in_ch = 8'($urandom); in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_ch = c; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    feed(c);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(ch_t'(s[i]));
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    sbuf.delete();
    for (int k = 0; k < 2; k++) begin held_c[k] = '0; held_t[k] = 1'b0; end
  endtask

  // Monitor: out must pulse exactly when a statement was accepted; results must hold otherwise
  task automatic chk(input int k, input logic o, input logic [CW-1:0] c, input logic t);
    exp_t e;
    bit want;
    want = (exp_q[k].size() != 0);
    checks++;
    if (o !== want) begin
      errors++;
      $display("FAIL pulse[%0d] t=%0t: out=%b expected %b", k, $time, o, want);
    end
    if (want) begin
      e = exp_q[k].pop_front();
      held_c[k] = e.cnt;
      held_t[k] = e.tc;
      popped[k]++;
    end
    checks++;
    if (c !== held_c[k] || t !== held_t[k]) begin
      errors++;
      $display("FAIL result[%0d] t=%0t: id_count=%0d type_char=%b expected id_count=%0d type_char=%b",
               k, $time, c, t, held_c[k], held_t[k]);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk(0, out_a, cnt_a, tc_a);
        chk(1, out_b, cnt_b, tc_b);
      end
    end
  end

  function automatic ch_t rand_idc(input bit first);
    int unsigned r;
    r = $urandom_range(first ? 52 : 62, 0);
    if (r < 26) return ch_t'(r + 97);
    if (r < 52) return ch_t'(r - 26 + 65);
    if (r == 52) return 8'h5F;
    return ch_t'(r - 53 + 48);
  endfunction

  function automatic ch_t rand_ws();
    return ($urandom_range(1, 0) != 0) ? 8'h20 : 8'h09;
  endfunction

  task automatic gen_str(input string t);
    for (int i = 0; i < t.len(); i++) gen.push_back(ch_t'(t[i]));
  endtask

  task automatic gen_id();
    string kws [5] = '{"int", "char", "in", "int_", "chars"};
    int unsigned len;
    if ($urandom_range(9, 0) == 0) begin
      gen_str(kws[$urandom_range(4, 0)]);
    end else begin
      len = $urandom_range(10, 1);
      gen.push_back(rand_idc(1'b1));
      for (int unsigned j = 1; j < len; j++) gen.push_back(rand_idc(1'b0));
    end
  endtask

  task automatic rand_stmt();
    int unsigned r, n, nid;
    gen.delete();
    if ($urandom_range(7, 0) == 0) gen.push_back(rand_ws());
    r = $urandom_range(9, 0);
    if (r < 5) gen_str("int");
    else if (r < 9) gen_str("char");
    else gen_str("chart");
    n = ($urandom_range(9, 0) == 0) ? 0 : $urandom_range(3, 1);
    repeat (n) gen.push_back(rand_ws());
    nid = ($urandom_range(9, 0) == 0) ? $urandom_range(18, 15) : $urandom_range(4, 1);
    for (int unsigned j = 0; j < nid; j++) begin
      if (j != 0) begin
        if ($urandom_range(1, 0) != 0) gen.push_back(rand_ws());
        gen.push_back(8'h2C);
        if ($urandom_range(1, 0) != 0) gen.push_back(rand_ws());
      end
      gen_id();
    end
    if ($urandom_range(1, 0) != 0) gen.push_back(rand_ws());
    if ($urandom_range(9, 0) == 0) gen.push_back(8'h2C);
    if ($urandom_range(11, 0) == 0) gen[$urandom_range(gen.size() - 1, 0)] = 8'($urandom);
    foreach (gen[i]) send(gen[i]);
    send(8'h3B);
  endtask

  initial begin
    string dir [16] = '{
      "int a, b1 ,_c;", "char  xx;int y;", "int int;", "int char;",
      "int integer, in, chars;", "int abcdefgh;", "int abcdefghi;", "int z;",
      "int a,;", "int ;", ";", "inta;", "int 1a;", "\tint\tq,r ;",
      "int a,b,c,d,e,f,g,h,i,j,k,l,m,n,o,p,q;", "char c_, int_, _9 ;"};

    reset = 1'b1; in_valid = 1'b0; in_ch = '0;
    for (int k = 0; k < 2; k++) begin
      held_c[k] = '0; held_t[k] = 1'b0; pushed[k] = 0; popped[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (out_a !== 1'b0 || cnt_a !== '0 || tc_a !== 1'b0 ||
        out_b !== 1'b0 || cnt_b !== '0 || tc_b !== 1'b0) begin
      errors++;
      $display("FAIL reset: out=%b/%b id_count=%0d/%0d type_char=%b/%b expected all 0",
               out_a, out_b, cnt_a, cnt_b, tc_a, tc_b);
    end
    mon_en = 1'b1;

    gap_lo = 0; gap_hi = 0;
    foreach (dir[i]) send_str(dir[i]);

    gap_lo = 1; gap_hi = 1;
    send_str("int a;");
    idle(3);

    gap_lo = 0; gap_hi = 2;
    send_str("int a");
    do_reset();
    send_str(";");
    send_str("char w;");
    idle(2);

    repeat (150) rand_stmt();
    idle(5);

    for (int k = 0; k < 2; k++) begin
      checks++;
      if (pushed[k] != popped[k] || exp_q[k].size() != 0) begin
        errors++;
        $display("FAIL drain[%0d]: pulses seen=%0d expected %0d", k, popped[k], pushed[k]);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
